// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory port arbiter: FSM states, owner
// encoding and a small width helper for the internal counters.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_t;

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int width_for(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/dmem_grant_logic.sv
// Grant decision between the CPU MEM stage and the DMA port, with a
// starvation counter that eventually forces a DMA win over a busy CPU.
module dmem_grant_logic
  import dmem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic cpu_req,
  input  logic dma_req,
  input  logic grant_en,
  output logic grant,
  output logic owner
);

  localparam int SW = width_for(STARVE_MAX);

  logic [SW-1:0] starve_cnt;
  logic          starved;
  logic          dma_wins;

  always_comb begin
    starved  = (starve_cnt == SW'(STARVE_MAX));
    dma_wins = dma_req & (~cpu_req | starved);
    grant    = grant_en & (cpu_req | dma_req);
    owner    = dma_wins ? OWN_DMA : OWN_CPU;
  end

  // Only contested CPU grants count toward starvation; any DMA grant clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (grant) begin
      if (owner == OWN_DMA) begin
        starve_cnt <= '0;
      end else if (dma_req && !starved) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares a single-port, possibly multi-cycle data RAM between the pipeline
// MEM stage and a DMA/loader port, stalling the pipeline during CPU accesses.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int STARVE_MAX  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead_M,
  input  logic        MemWrite_M,
  input  logic [31:0] ALUOut_M,
  input  logic [31:0] WriteData_M,
  output logic [31:0] ReadData_M,
  output logic        StallMem,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic [31:0] dma_rdata,
  output logic        dma_ack,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  localparam int CW = width_for(WAIT_CYCLES - 1);

  arb_state_t    state;
  arb_state_t    state_nxt;
  owner_t        owner_q;
  logic [CW-1:0] cnt;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic          we_q;
  logic [31:0]   rd_q;
  logic [31:0]   dma_rdata_q;

  logic cpu_req;
  logic grant;
  logic grant_owner;
  logic commit;
  logic cpu_done;

  assign cpu_req = MemRead_M | MemWrite_M;
  assign commit  = (state == BUSY) && (cnt == '0);

  dmem_grant_logic #(
    .STARVE_MAX(STARVE_MAX)
  ) u_grant (
    .clk     (clk),
    .reset   (reset),
    .cpu_req (cpu_req),
    .dma_req (dma_req),
    .grant_en(state == IDLE),
    .grant   (grant),
    .owner   (grant_owner)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = BUSY;
      BUSY:    if (commit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Request is latched at grant so the RAM sees stable values for the whole access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q     <= OWN_CPU;
      cnt         <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      rd_q        <= '0;
      dma_rdata_q <= '0;
    end else begin
      if (grant) begin
        owner_q <= owner_t'(grant_owner);
        cnt     <= CW'(WAIT_CYCLES - 1);
        if (grant_owner == OWN_DMA) begin
          addr_q  <= dma_addr;
          wdata_q <= dma_wdata;
          we_q    <= dma_we;
        end else begin
          addr_q  <= ALUOut_M;
          wdata_q <= WriteData_M;
          we_q    <= MemWrite_M;
        end
      end else if ((state == BUSY) && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
      end
      if (commit) begin
        rd_q <= ram_rdata;
      end
      // DMA read data is captured alongside rd_q so it is already valid during dma_ack.
      if (commit && (owner_q == OWN_DMA)) begin
        dma_rdata_q <= ram_rdata;
      end
    end
  end

  always_comb begin
    cpu_done   = (state == DONE) && (owner_q == OWN_CPU);
    ram_we     = commit & we_q;
    ram_addr   = addr_q;
    ram_wdata  = wdata_q;
    ReadData_M = cpu_done ? rd_q : 32'h0;
    StallMem   = cpu_req & ~cpu_done;
    dma_ack    = (state == DONE) && (owner_q == OWN_DMA);
    dma_rdata  = dma_rdata_q;
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: a cycle-by-cycle vector table plus
// sequences for arbitration fairness, reset mid-access and WAIT_CYCLES=1.
module tb_dmem_port_arbiter;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        dreq;
    logic        dwe;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic        e_stall;
    logic [31:0] e_rdata;
    logic        e_we;
    logic [31:0] e_raddr;
    logic        e_ack;
    logic [31:0] e_drdata;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        preload;
  logic        MemRead_M, MemWrite_M;
  logic [31:0] ALUOut_M, WriteData_M, ReadData_M;
  logic        StallMem;
  logic        dma_req, dma_we;
  logic [31:0] dma_addr, dma_wdata, dma_rdata;
  logic        dma_ack;
  logic        ram_we;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;

  logic        w1_rd;
  logic [31:0] w1_addr;
  logic [31:0] w1_rdata, w1_dma_rdata, w1_ram_addr, w1_ram_wdata, w1_ram_rdata;
  logic        w1_stall, w1_dma_ack, w1_ram_we;

  int total = 0;
  int bad   = 0;
  int we_hits = 0;

  logic [31:0] mem [0:63];

  dmem_port_arbiter #(.WAIT_CYCLES(2), .STARVE_MAX(2)) dut (
    .clk(clk), .reset(reset),
    .MemRead_M(MemRead_M), .MemWrite_M(MemWrite_M),
    .ALUOut_M(ALUOut_M), .WriteData_M(WriteData_M),
    .ReadData_M(ReadData_M), .StallMem(StallMem),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ack(dma_ack),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  dmem_port_arbiter #(.WAIT_CYCLES(1), .STARVE_MAX(2)) dut_w1 (
    .clk(clk), .reset(reset),
    .MemRead_M(w1_rd), .MemWrite_M(1'b0),
    .ALUOut_M(w1_addr), .WriteData_M(32'h0),
    .ReadData_M(w1_rdata), .StallMem(w1_stall),
    .dma_req(1'b0), .dma_we(1'b0), .dma_addr(32'h0), .dma_wdata(32'h0),
    .dma_rdata(w1_dma_rdata), .dma_ack(w1_dma_ack),
    .ram_we(w1_ram_we), .ram_addr(w1_ram_addr), .ram_wdata(w1_ram_wdata),
    .ram_rdata(w1_ram_rdata)
  );

  // Main RAM model: combinational read, write on the clock edge.
  assign ram_rdata = mem[ram_addr[7:2]];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem[2] <= 32'hDEADBEEF;
    end else if (ram_we) begin
      mem[ram_addr[7:2]] <= ram_wdata;
    end
  end

  always @(posedge clk) if (ram_we) we_hits <= we_hits + 1;

  // Second RAM is a read-only pattern keyed on address.
  assign w1_ram_rdata = w1_ram_addr ^ 32'h5A5A0000;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    MemRead_M   = v.rd;
    MemWrite_M  = v.wr;
    ALUOut_M    = v.addr;
    WriteData_M = v.wdata;
    dma_req     = v.dreq;
    dma_we      = v.dwe;
    dma_addr    = v.daddr;
    dma_wdata   = v.dwdata;
  endtask

  task automatic clearInputs();
    MemRead_M = 0; MemWrite_M = 0; ALUOut_M = 0; WriteData_M = 0;
    dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
  endtask

  task automatic cpuAccess(input logic w, input logic [31:0] a, input logic [31:0] d,
                           output logic [31:0] r, output int sc);
    logic done;
    done = 0; sc = 0; r = 32'h0;
    @(posedge clk); #1;
    MemWrite_M = w; MemRead_M = ~w; ALUOut_M = a; WriteData_M = d;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (!StallMem) begin
        r = ReadData_M;
        done = 1;
        break;
      end
      sc++;
      @(posedge clk); #1;
    end
    checkOutput("cpu_access_done", {31'b0, done}, 32'd1);
    @(posedge clk); #1;
    MemRead_M = 0; MemWrite_M = 0;
  endtask

  function automatic vec_t mk(logic rd, logic wr, logic [31:0] a, logic [31:0] d,
                              logic dq, logic dw, logic [31:0] da, logic [31:0] dd,
                              logic st, logic [31:0] rdat, logic we, logic [31:0] ra,
                              logic ack, logic [31:0] drd);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = a; v.wdata = d;
    v.dreq = dq; v.dwe = dw; v.daddr = da; v.dwdata = dd;
    v.e_stall = st; v.e_rdata = rdat; v.e_we = we; v.e_raddr = ra;
    v.e_ack = ack; v.e_drdata = drd;
    return v;
  endfunction

  vec_t        vecs [28];
  int          got [6];
  int          exp_order [6];
  logic [31:0] r;
  int          sc;
  int          hits0;
  int          w1_sc;
  logic        w1_done;
  logic        found;

  initial begin
    // CPU load, CPU store with read-back, DMA write with a CPU load queued behind it,
    // then a DMA read whose request drops right after the grant.
    vecs[0]  = mk(1,0,32'h8,0,          0,0,0,0,                   1,32'h0,0,32'h0,0,32'h0);
    vecs[1]  = mk(1,0,32'h8,0,          0,0,0,0,                   1,32'h0,0,32'h8,0,32'h0);
    vecs[2]  = mk(1,0,32'h8,0,          0,0,0,0,                   1,32'h0,0,32'h8,0,32'h0);
    vecs[3]  = mk(1,0,32'h8,0,          0,0,0,0,                   0,32'hDEADBEEF,0,32'h8,0,32'h0);
    vecs[4]  = mk(0,0,0,0,              0,0,0,0,                   0,32'h0,0,32'h8,0,32'h0);
    vecs[5]  = mk(0,1,32'h4,32'h12345678, 0,0,0,0,                 1,32'h0,0,32'h8,0,32'h0);
    vecs[6]  = mk(0,1,32'h4,32'h12345678, 0,0,0,0,                 1,32'h0,0,32'h4,0,32'h0);
    vecs[7]  = mk(0,1,32'h4,32'h12345678, 0,0,0,0,                 1,32'h0,1,32'h4,0,32'h0);
    vecs[8]  = mk(0,1,32'h4,32'h12345678, 0,0,0,0,                 0,32'h0,0,32'h4,0,32'h0);
    vecs[9]  = mk(1,0,32'h4,0,          0,0,0,0,                   1,32'h0,0,32'h4,0,32'h0);
    vecs[10] = mk(1,0,32'h4,0,          0,0,0,0,                   1,32'h0,0,32'h4,0,32'h0);
    vecs[11] = mk(1,0,32'h4,0,          0,0,0,0,                   1,32'h0,0,32'h4,0,32'h0);
    vecs[12] = mk(1,0,32'h4,0,          0,0,0,0,                   0,32'h12345678,0,32'h4,0,32'h0);
    vecs[13] = mk(0,0,0,0,              0,0,0,0,                   0,32'h0,0,32'h4,0,32'h0);
    vecs[14] = mk(0,0,0,0,              1,1,32'h10,32'hA5A5A5A5,   0,32'h0,0,32'h4,0,32'h0);
    vecs[15] = mk(1,0,32'h10,0,         1,1,32'h10,32'hA5A5A5A5,   1,32'h0,0,32'h10,0,32'h0);
    vecs[16] = mk(1,0,32'h10,0,         1,1,32'h10,32'hA5A5A5A5,   1,32'h0,1,32'h10,0,32'h0);
    vecs[17] = mk(1,0,32'h10,0,         1,1,32'h10,32'hA5A5A5A5,   1,32'h0,0,32'h10,1,32'h0);
    vecs[18] = mk(1,0,32'h10,0,         0,0,0,0,                   1,32'h0,0,32'h10,0,32'h0);
    vecs[19] = mk(1,0,32'h10,0,         0,0,0,0,                   1,32'h0,0,32'h10,0,32'h0);
    vecs[20] = mk(1,0,32'h10,0,         0,0,0,0,                   1,32'h0,0,32'h10,0,32'h0);
    vecs[21] = mk(1,0,32'h10,0,         0,0,0,0,                   0,32'hA5A5A5A5,0,32'h10,0,32'h0);
    vecs[22] = mk(0,0,0,0,              0,0,0,0,                   0,32'h0,0,32'h10,0,32'h0);
    vecs[23] = mk(0,0,0,0,              1,0,32'h8,0,               0,32'h0,0,32'h10,0,32'h0);
    vecs[24] = mk(0,0,0,0,              0,0,0,0,                   0,32'h0,0,32'h8,0,32'h0);
    vecs[25] = mk(0,0,0,0,              0,0,0,0,                   0,32'h0,0,32'h8,0,32'h0);
    vecs[26] = mk(0,0,0,0,              0,0,0,0,                   0,32'h0,0,32'h8,1,32'hDEADBEEF);
    vecs[27] = mk(0,0,0,0,              0,0,0,0,                   0,32'h0,0,32'h8,0,32'hDEADBEEF);
    exp_order = '{0, 0, 1, 0, 0, 1};

    reset = 1; preload = 1; w1_rd = 0; w1_addr = 0;
    clearInputs();
    @(posedge clk); #1;
    preload = 0;
    checkOutput("rst_ram_we", {31'b0, ram_we}, 32'h0);
    checkOutput("rst_ram_addr", ram_addr, 32'h0);
    checkOutput("rst_ram_wdata", ram_wdata, 32'h0);
    checkOutput("rst_rdata", ReadData_M, 32'h0);
    checkOutput("rst_stall", {31'b0, StallMem}, 32'h0);
    checkOutput("rst_ack", {31'b0, dma_ack}, 32'h0);
    checkOutput("rst_dma_rdata", dma_rdata, 32'h0);
    @(posedge clk); #1;
    reset = 0;

    for (int i = 0; i < 28; i++) begin
      @(posedge clk); #1;
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("v%0d_stall", i), {31'b0, StallMem}, {31'b0, vecs[i].e_stall});
      checkOutput($sformatf("v%0d_rdata", i), ReadData_M, vecs[i].e_rdata);
      checkOutput($sformatf("v%0d_ram_we", i), {31'b0, ram_we}, {31'b0, vecs[i].e_we});
      checkOutput($sformatf("v%0d_ram_addr", i), ram_addr, vecs[i].e_raddr);
      checkOutput($sformatf("v%0d_ack", i), {31'b0, dma_ack}, {31'b0, vecs[i].e_ack});
      checkOutput($sformatf("v%0d_dma_rdata", i), dma_rdata, vecs[i].e_drdata);
      if (i == 7)  checkOutput("sw_wdata", ram_wdata, 32'h12345678);
      if (i == 16) checkOutput("dma_wdata", ram_wdata, 32'hA5A5A5A5);
    end
    @(posedge clk); #1;
    clearInputs();
    checkOutput("mem1_written", mem[1], 32'h12345678);
    checkOutput("mem4_written", mem[4], 32'hA5A5A5A5);

    // Both sides requesting back-to-back: starvation counter must force every third grant to DMA.
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    MemRead_M = 1; ALUOut_M = 32'h4; dma_req = 1; dma_we = 0; dma_addr = 32'h8;
    for (int n = 0; n < 6; n++) begin
      got[n] = 9;
      found = 0;
      for (int k = 0; k < 8 && !found; k++) begin
        @(posedge clk); #2;
        if (dma_ack) begin
          got[n] = 1; found = 1;
          checkOutput($sformatf("order%0d_dma_rdata", n), dma_rdata, 32'hDEADBEEF);
        end else if (!StallMem) begin
          got[n] = 0; found = 1;
          checkOutput($sformatf("order%0d_cpu_rdata", n), ReadData_M, 32'h12345678);
        end
      end
      checkOutput($sformatf("grant_order%0d", n), got[n], exp_order[n]);
      if (got[n] == 1) begin
        @(posedge clk); #2;
        checkOutput($sformatf("ack_pulse%0d", n), {31'b0, dma_ack}, 32'h0);
      end
    end
    @(posedge clk); #1;
    clearInputs();
    reset = 1;
    @(posedge clk); #1;
    reset = 0;

    // Reset lands in the middle of a CPU store: nothing may reach the RAM.
    hits0 = we_hits;
    MemWrite_M = 1; ALUOut_M = 32'h20; WriteData_M = 32'hCAFEF00D;
    @(posedge clk); #1;
    reset = 1; MemWrite_M = 0;
    #1;
    checkOutput("midrst_ram_we", {31'b0, ram_we}, 32'h0);
    checkOutput("midrst_ram_addr", ram_addr, 32'h0);
    checkOutput("midrst_ram_wdata", ram_wdata, 32'h0);
    checkOutput("midrst_rdata", ReadData_M, 32'h0);
    checkOutput("midrst_stall", {31'b0, StallMem}, 32'h0);
    checkOutput("midrst_ack", {31'b0, dma_ack}, 32'h0);
    checkOutput("midrst_dma_rdata", dma_rdata, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("midrst_mem_untouched", mem[8], 32'h0);
    checkOutput("midrst_no_we", we_hits - hits0, 32'h0);
    cpuAccess(1'b1, 32'h20, 32'hCAFEF00D, r, sc);
    checkOutput("post_rst_sw_stall", sc, 32'd3);
    cpuAccess(1'b0, 32'h20, 32'h0, r, sc);
    checkOutput("post_rst_lw_stall", sc, 32'd3);
    checkOutput("post_rst_lw_data", r, 32'hCAFEF00D);
    checkOutput("post_rst_mem", mem[8], 32'hCAFEF00D);

    // Single-cycle RAM: a load stalls for exactly two cycles.
    w1_sc = 0; w1_done = 0;
    @(posedge clk); #1;
    w1_rd = 1; w1_addr = 32'h8;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (!w1_stall) begin
        checkOutput("w1_lw_data", w1_rdata, 32'h5A5A0008);
        w1_done = 1;
        break;
      end
      w1_sc++;
      @(posedge clk); #1;
    end
    checkOutput("w1_done", {31'b0, w1_done}, 32'd1);
    checkOutput("w1_stall_cycles", w1_sc, 32'd2);
    @(posedge clk); #1;
    w1_rd = 0;
    #1;
    checkOutput("w1_idle_rdata", w1_rdata, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
